// File: rtl/word_stage_pkg.sv
// Shared definitions for the serial word adder: FSM encoding and default width.
package word_stage_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : word_stage_pkg

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder, reused by the serial adder every SHIFT cycle.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic a_xor_b_s;

    assign a_xor_b_s = a ^ b;
    assign s         = a_xor_b_s ^ cin;
    assign cout      = (a & b) | (cin & a_xor_b_s);

endmodule : full_adder_bit

// File: rtl/serial_word_adder.sv
// Bit-serial adder: captures a word pair, adds one bit per cycle through a single
// full adder, and presents {carry, sum} until the consumer takes it.
module serial_word_adder
    import word_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wordValid,
    input  logic [WIDTH-1:0] wordA,
    input  logic [WIDTH-1:0] wordB,
    output logic             wordReady,
    output logic [WIDTH:0]   sum,
    output logic             sumValid,
    input  logic             sumReady,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH:0]     sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_s_s;
    logic               fa_cout_s;
    logic               last_bit_s;

    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    assign last_bit_s = (cnt_q == CNT_W'(WIDTH - 1));

    // State register and datapath flops; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: one pair in flight, WIDTH shift cycles, hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wordValid) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (sumReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: capture operands in IDLE, add/shift LSB-first in SHIFT, publish on the last bit.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wordValid) begin
                    a_d     = wordA;
                    b_d     = wordB;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    a_d     = a_q;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1'b1;
                b_d     = b_q >> 1'b1;
                res_d   = {fa_s_s, res_q[WIDTH-1:1]};
                carry_d = fa_cout_s;
                if (last_bit_s) begin
                    cnt_d = '0;
                    sum_d = {fa_cout_s, fa_s_s, res_q[WIDTH-1:1]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                sum_d = sum_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Output decode: handshake and status flags follow the state register directly.
    always_comb begin
        wordReady = 1'b0;
        busy      = 1'b0;
        sumValid  = 1'b0;
        case (state_q)
            IDLE:    wordReady = 1'b1;
            SHIFT:   busy      = 1'b1;
            DONE:    sumValid  = 1'b1;
            default: wordReady = 1'b0;
        endcase
    end

    assign sum = sum_q;

endmodule : serial_word_adder

// File: tb/tb_serial_word_adder.sv
// Self-checking bench for serial_word_adder (WIDTH=4) with an expected-sum scoreboard.
module tb_serial_word_adder;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         wordValid;
    logic [W-1:0] wordA;
    logic [W-1:0] wordB;
    logic         wordReady;
    logic [W:0]   sum;
    logic         sumValid;
    logic         sumReady;
    logic         busy;

    int total;
    int bad;
    logic [W:0] exp_q[$];

    serial_word_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wordValid (wordValid),
        .wordA     (wordA),
        .wordB     (wordB),
        .wordReady (wordReady),
        .sum       (sum),
        .sumValid  (sumValid),
        .sumReady  (sumReady),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one pair at the current negedge; hold wordValid across exactly one rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] e, input bit push);
        wordA     = a;
        wordB     = b;
        wordValid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        wordValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wordValid = 1'b0; wordA = '0; wordB = '0; sumReady = 1'b0;
        #3;
        total++;
        if (sumValid !== 1'b0 || busy !== 1'b0 || sum !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: sumValid=%0b busy=%0b sum=%0d, want 0/0/0", sumValid, busy, sum);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (wordReady !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: wordReady=%0b want 1", wordReady);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta [3];
        logic [W-1:0] tb [3];
        logic [W:0]   te [3];
        logic [W:0]   e;
        ta[0] = 4'd14; tb[0] = 4'd15; te[0] = 5'b11101;
        ta[1] = 4'd15; tb[1] = 4'd1;  te[1] = 5'b10000;
        ta[2] = 4'd0;  tb[2] = 4'd0;  te[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], tb[i], te[i], 1'b1);
            total++;
            if (busy !== 1'b1 || wordReady !== 1'b0) begin
                bad++;
                $display("FAIL basic_busy[%0d]: busy=%0b wordReady=%0b want 1/0", i, busy, wordReady);
            end
            for (int k = 1; k <= W; k++) begin
                @(negedge clk);
                total++;
                if (sumValid !== (k == W)) begin
                    bad++;
                    $display("FAIL basic_latency[%0d] edge %0d: sumValid=%0b want %0b", i, k, sumValid, (k == W));
                end
            end
            e = exp_q.pop_front();
            total++;
            if (sum !== e) begin
                bad++;
                $display("FAIL basic_sum[%0d]: got %0d want %0d", i, sum, e);
            end
            sumReady = 1'b1;
            @(negedge clk);
            sumReady = 1'b0;
            total++;
            if (wordReady !== 1'b1 || sumValid !== 1'b0 || sum !== e) begin
                bad++;
                $display("FAIL basic_release[%0d]: wordReady=%0b sumValid=%0b sum=%0d want 1/0/%0d",
                         i, wordReady, sumValid, sum, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] e;
        issue(4'd5, 4'd6, 5'd11, 1'b1);
        for (int k = 1; k <= W; k++) @(negedge clk);
        e = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            total++;
            if (sumValid !== 1'b1 || sum !== e || wordReady !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: sumValid=%0b sum=%0d wordReady=%0b want 1/%0d/0",
                         c, sumValid, sum, wordReady, e);
            end
            @(negedge clk);
        end
        sumReady = 1'b1;
        @(negedge clk);
        sumReady = 1'b0;
        total++;
        if (wordReady !== 1'b1 || sumValid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: wordReady=%0b sumValid=%0b want 1/0", wordReady, sumValid);
        end
    endtask

    task automatic test_ignore_during_shift();
        logic [W:0] e;
        issue(4'd8, 4'd9, 5'd17, 1'b1);
        wordA = 4'd14; wordB = 4'd15; wordValid = 1'b1;
        total++;
        if (wordReady !== 1'b0) begin
            bad++;
            $display("FAIL ign_ready: wordReady=%0b want 0", wordReady);
        end
        for (int k = 1; k <= W; k++) @(negedge clk);
        wordValid = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (sumValid !== 1'b1 || sum !== e) begin
            bad++;
            $display("FAIL ign_sum: sumValid=%0b sum=%0d want 1/%0d", sumValid, sum, e);
        end
        sumReady = 1'b1;
        @(negedge clk);
        sumReady = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || wordReady !== 1'b1) begin
            bad++;
            $display("FAIL ign_not_taken: busy=%0b wordReady=%0b want 0/1", busy, wordReady);
        end
    endtask

    task automatic test_reset_abort();
        logic [W:0] e;
        issue(4'd10, 4'd11, 5'd21, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || wordReady !== 1'b1 || sumValid !== 1'b0 || sum !== 5'd0) begin
            bad++;
            $display("FAIL abort_reset: busy=%0b wordReady=%0b sumValid=%0b sum=%0d want 0/1/0/0",
                     busy, wordReady, sumValid, sum);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(4'd3, 4'd4, 5'd7, 1'b1);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            total++;
            if (sumValid !== (k == W)) begin
                bad++;
                $display("FAIL abort_latency edge %0d: sumValid=%0b want %0b", k, sumValid, (k == W));
            end
        end
        e = exp_q.pop_front();
        total++;
        if (sum !== e) begin
            bad++;
            $display("FAIL abort_sum: got %0d want %0d", sum, e);
        end
        sumReady = 1'b1;
        @(negedge clk);
        sumReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   e;
        sumReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            total++;
            if (wordReady !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: wordReady=%0b want 1", i, wordReady);
            end
            issue(a, b, {1'b0, a} + {1'b0, b}, 1'b1);
            for (int k = 1; k <= W; k++) @(negedge clk);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b2b_queue[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (sumValid !== 1'b1 || sum !== e) begin
                    bad++;
                    $display("FAIL b2b_sum[%0d]: %0d+%0d sumValid=%0b sum=%0d want 1/%0d",
                             i, a, b, sumValid, sum, e);
                end
            end
            @(negedge clk);
        end
        sumReady = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignore_during_shift();
        test_reset_abort();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d entries remain, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_word_adder
